// File: rtl/stopwatch_pkg.sv
// Shared types and display helpers for the lap stopwatch.
// Segment bit j drives segment j (0 top ... 6 middle); a 0 lights the segment.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sw_state_t;

    localparam int TENTHS_ONEHOT = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Non-BCD codes cannot occur from the counters but show blank if they do.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) seg = SEG_DIGIT[i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// One decade of the ripple BCD counter: steps on carry_in, wraps 9 -> 0.
// carry_out is combinational so a whole chain advances in a single tick.
module sw_bcd_digit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clr,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = carry_in && (digit == 4'd9);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (carry_in) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with tenths plus NUM_DIGITS BCD seconds, start/stop and lap/clear buttons,
// sticky overflow and registered seven-segment / one-hot tenths display outputs.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    STRTSTOP,
    input  logic                    LAP,
    output logic [7*NUM_DIGITS-1:0] SEGOUT,
    output logic [9:0]              TENTHSOUT,
    output logic                    RUNNING,
    output logic                    LAPHELD,
    output logic                    OVERFLOW
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [TENTHS_ONEHOT-1:0] TENTHS_ONE = TENTHS_ONEHOT'(1);

    sw_state_t state;

    logic [1:0]    ss_sync;
    logic [1:0]    lap_sync;
    logic          ss_prev;
    logic          lap_prev;
    logic          start_ev;
    logic          lap_ev;
    logic          clr;
    logic          tick;
    logic [PW-1:0] pre;

    logic [NUM_DIGITS:0][3:0] cnt;
    logic [NUM_DIGITS+1:0]    carry;

    // Buttons idle high, so synchroniser and edge history reset to released.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ss_sync  <= 2'b11;
            lap_sync <= 2'b11;
            ss_prev  <= 1'b1;
            lap_prev <= 1'b1;
        end else begin
            ss_sync  <= {ss_sync[0], STRTSTOP};
            lap_sync <= {lap_sync[0], LAP};
            ss_prev  <= ss_sync[1];
            lap_prev <= lap_sync[1];
        end
    end

    assign start_ev = ss_prev & ~ss_sync[1];
    assign lap_ev   = lap_prev & ~lap_sync[1];

    // Start wins over a coincident lap, so a clear needs lap alone while stopped.
    assign clr  = (state == STOP) && !start_ev && lap_ev && !LAPHELD;
    assign tick = (state == RUN) && (pre == PRE_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (state == RUN) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // cnt[0] is tenths, cnt[i] is whole-second digit i-1.
    assign carry[0] = tick;

    for (genvar g = 0; g <= NUM_DIGITS; g++) begin : g_digit
        sw_bcd_digit u_digit (
            .CLK       (CLK),
            .RESET     (RESET),
            .clr       (clr),
            .carry_in  (carry[g]),
            .digit     (cnt[g]),
            .carry_out (carry[g+1])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            RUNNING  <= 1'b0;
            LAPHELD  <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (clr) begin
                OVERFLOW <= 1'b0;
            end else if (carry[NUM_DIGITS+1]) begin
                OVERFLOW <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ev) begin
                        state   <= RUN;
                        RUNNING <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_ev) begin
                        state   <= STOP;
                        RUNNING <= 1'b0;
                    end else if (lap_ev) begin
                        LAPHELD <= ~LAPHELD;
                    end
                end
                STOP: begin
                    if (start_ev) begin
                        state   <= RUN;
                        RUNNING <= 1'b1;
                    end else if (lap_ev) begin
                        if (LAPHELD) begin
                            LAPHELD <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    RUNNING <= 1'b0;
                    LAPHELD <= 1'b0;
                end
            endcase
        end
    end

    // Display registers follow the count one cycle late and freeze during a lap hold.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEGOUT    <= {NUM_DIGITS{SEG_DIGIT[0]}};
            TENTHSOUT <= TENTHS_ONE;
        end else if (!LAPHELD) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                SEGOUT[7*i +: 7] <= bcd_to_seg(cnt[i+1]);
            end
            TENTHSOUT <= TENTHS_ONE << cnt[0];
        end
    end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Parametrised successor to the team's tenths/ones/tens stopwatch.
- Counts tenths of seconds plus NUM_DIGITS BCD whole-second digits, driven by an internal prescaler from CLK.
- Adds a LAP button (split hold / clear), an overflow flag and a status output.
- Drives active-low seven-segment digit buses and a one-hot tenths bar; sits between the board buttons and the display pins.

Parameters:
- CLK_DIV, 10, CLK cycles per tenth-second tick (≥2).
- NUM_DIGITS, 2, whole-second BCD digits (1..6); max display is (10^NUM_DIGITS − 0.1) s.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STRTSTOP  in  1  active-low start/stop button, asynchronous to CLK.
- LAP  in  1  active-low lap/clear button, asynchronous to CLK.
- SEGOUT  out  7*NUM_DIGITS  seven-segment codes, digit i at [7i+6:7i] (digit 0 = ones); bit j = segment j (0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle); 0 = lit.
- TENTHSOUT  out  10  one-hot tenths, bit n set when tenths = n.
- RUNNING  out  1  high in RUN.
- LAPHELD  out  1  high while the display is frozen.
- OVERFLOW  out  1  sticky; set on full-scale wrap.

Behaviour:
- Reset (async, RESET=1):
  - Counters, prescaler and display registers are zero; state IDLE.
  - SEGOUT shows all digits "0" (7'b1000000 each); TENTHSOUT = 10'b0000000001.
  - RUNNING = LAPHELD = OVERFLOW = 0; synchroniser flops reset to 1 (released).
- Inputs: each button passes through a 2-flop synchroniser and then a falling-edge detector. A press yields a 1-cycle event; the resulting state and outputs change on the 3rd rising edge after the input falls (setup met). A held button produces exactly one event.
- States: IDLE, RUN, STOP.
  - IDLE + start event → RUN.
  - RUN + start event → STOP.
  - STOP + start event → RUN; counting resumes from the held value with the prescaler retained.
  - RUN + lap event → toggle LAPHELD. Counting continues; while LAPHELD=1 the display registers do not update.
  - STOP + lap event, LAPHELD=1 → LAPHELD=0; the display shows the live count.
  - STOP + lap event, LAPHELD=0 → clear the count, prescaler and OVERFLOW; go to IDLE.
  - IDLE + lap event → no effect.
  - Start and lap events in the same cycle: start is taken, lap is dropped.
- Prescaler: counts 0..CLK_DIV−1 only in RUN, frozen otherwise. The tick is asserted in the cycle the prescaler equals CLK_DIV−1, and the prescaler then wraps to 0.
- Counting: on a tick, tenths increments 0..9. Each BCD digit i increments when all lower digits and tenths are at 9, and wraps 9→0.
- Full-scale wrap: all digits at 9 and tenths=9 on a tick → everything goes to 0, OVERFLOW set, keeps running. OVERFLOW stays set until RESET or the clear event.
- Display: SEGOUT/TENTHSOUT are registered from the count, so they update 1 cycle after the tick edge unless LAPHELD.
- Segment codes, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any non-BCD value displays 1111111 (blank); unreachable in normal operation.
- RUNNING is registered from the state, with no combinational paths from inputs to outputs.

Decomposition:
- stopwatch_pkg:
  - state enum (IDLE, RUN, STOP);
  - SEG_DIGIT[0:9] constant table and SEG_BLANK;
  - function bcd_to_seg;
  - TENTHS_ONEHOT width constant.
- Sub-module sw_bcd_digit (one per tenths/whole digit via generate): inputs CLK, RESET, clr, carry_in; outputs digit[3:0], carry_out (carry_in & digit==9). Synchroniser and edge detection stay inline.

Test Plan (CLK_DIV=4, NUM_DIGITS=2, 20 ns clock):
- Reset held 100 ns, buttons high → SEGOUT = {1000000,1000000}, TENTHSOUT = 0x001, RUNNING=0; RUNNING and outputs stay put during reset.
- STRTSTOP pulled low and held → RUNNING=1 on the 3rd edge. After 40 further clocks tenths=0, ones digit=1111001, with TENTHSOUT walking 0x001→0x002→…→0x200→0x001.
- In RUN, press LAP at 0.3 s → LAPHELD=1, display frozen at 0.3 while count continues. Stop at 1.2 s: display still 0.3. LAP again → display 1.2, LAPHELD=0. LAP again → IDLE, all zero.
- Preload via run to 99.8 s → after 2 ticks display 00.0 and OVERFLOW=1, still running. Stop then LAP clears OVERFLOW.
- STRTSTOP and LAP fall in the same cycle from IDLE → RUN entered, LAPHELD stays 0.
- Assert RESET mid-RUN between ticks → immediate zero and IDLE (asynchronous). After release, the next counting begins only after a fresh start press.
